pe_input_feeder: RTL and testbench
==================================

PE_INPUT_FEEDER -- requirements
Module: pe_input_feeder

Interface
REQ-001 Parameter DATAWD, default 16, width of one input-pixel word.
REQ-002 Parameter ADDRWD, default 12, global-buffer read address width.
REQ-003 Parameter PCHWD, default 4, channel-count width (Pch 1..12).
REQ-004 Parameter ROWWD, default 8, row-tile length width (1..255).
REQ-005 One clock; reset is synchronous and active-high: i_clk input 1, rising-edge clock.
REQ-006 i_rst  input  1  synchronous active-high reset.
REQ-007 i_start  input  1  one-cycle start pulse; samples config inputs; ignored unless idle.
REQ-008 i_abort  input  1  cancels the current transfer.
REQ-009 i_base_addr  input  ADDRWD  address of channel 0, pixel 0.
REQ-010 i_pch  input  PCHWD  channels per pixel, 1..12.
REQ-011 i_row_len  input  ROWWD  pixels in the row tile, 1..255.
REQ-012 i_pch_stride  input  ADDRWD  address distance between channel planes.
REQ-013 o_sram_ren  output  1  buffer read enable.
REQ-014 o_sram_raddr  output  ADDRWD  buffer read address.
REQ-015 i_sram_rdata  input  DATAWD  read data, valid exactly 1 cycle after o_sram_ren.
REQ-016 o_Input_rdy  output  1  word offered to the PE.
REQ-017 i_Input_ack  input  1  PE accepts; a transfer occurs when rdy and ack are both high.
REQ-018 o_Input_data  output  DATAWD  offered word.
REQ-019 o_busy  output  1  high outside IDLE.
REQ-020 o_done  output  1  one-cycle pulse after the last transfer.

Function
REQ-021 States: IDLE, RUN, DRAIN; IDLE->RUN on i_start; RUN->DRAIN when the last read issues; DRAIN->IDLE on the last transfer; any state->IDLE on i_abort.
REQ-022 Order: pixel outer, channel inner; element (p,c) address = base + p + c*pch_stride, modulo 2^ADDRWD (wrap silently).
REQ-023 Total words = i_pch*i_row_len, sampled at start; later config changes have no effect.
REQ-024 Internal 2-entry FIFO holds returned data; read issues only when FIFO occupancy + reads in flight < 2.
REQ-025 o_Input_rdy = FIFO non-empty; o_Input_data = FIFO head.
REQ-026 Once rdy is asserted, data holds stable until acked; rdy never drops without ack except on abort/reset.
REQ-027 Simultaneous push (read return) and pop (transfer) in the same cycle is legal and keeps occupancy unchanged.
REQ-028 Sustained throughput is 1 word/cycle with ack held high; first rdy is 2 cycles after i_start.
REQ-029 o_done pulses in the cycle after the final transfer; not asserted on abort.
REQ-030 i_abort: FIFO flushed and in-flight read data discarded; rdy low the next cycle.
REQ-031 i_start while not IDLE is ignored; i_start and i_abort together: abort wins.
REQ-032 Pixel/channel counters: channel resets to 0 and pixel increments when channel = i_pch-1.
REQ-033 i_pch=1, i_row_len=1 transfers exactly one word.

Reset
REQ-034 On i_rst: state IDLE, FIFO empty, counters 0, o_sram_ren=0, o_sram_raddr=0, o_Input_rdy=0, o_Input_data=0, o_busy=0, o_done=0.
REQ-035 Reset mid-transfer behaves as abort; the returning read data in the next cycle is discarded.

Verification
REQ-036 base=0x100, pch=3, row_len=4, stride=0x40, ack always high -> 12 transfers, addresses 0x100,0x140,0x180,0x101..0x183, back-to-back, done 1 cycle after the 12th.
REQ-037 Same config, ack random 30% -> identical data sequence, no drop or duplicate, data stable while rdy&&!ack.
REQ-038 pch=1, row_len=1 -> exactly one read, one transfer, done pulse, busy low the following cycle.
REQ-039 base=0xFFE, pch=2, stride=1, ADDRWD=12 -> addresses wrap 0xFFE,0xFFF,0xFFF,0x000.
REQ-040 Abort after 5 of 12 transfers with ack low -> rdy low next cycle, no done, a new start then delivers a full fresh sequence.
REQ-041 Ack held low 20 cycles after start -> at most 2 reads issued, then resumes 1/cycle on ack.

Source files
------------

// File: rtl/pe_input_feeder_if.sv
// Buffer-read and PE-handshake bundle of the input feeder.
// master = feeder side, slave = buffer/PE side.
interface pe_input_feeder_if #(
  parameter int DATAWD = 16,
  parameter int ADDRWD = 12
);
  logic              o_sram_ren;
  logic [ADDRWD-1:0] o_sram_raddr;
  logic [DATAWD-1:0] i_sram_rdata;
  logic              o_Input_rdy;
  logic              i_Input_ack;
  logic [DATAWD-1:0] o_Input_data;

  modport master (
    output o_sram_ren, o_sram_raddr, o_Input_rdy, o_Input_data,
    input  i_sram_rdata, i_Input_ack
  );

  modport slave (
    input  o_sram_ren, o_sram_raddr, o_Input_rdy, o_Input_data,
    output i_sram_rdata, i_Input_ack
  );
endinterface

// File: rtl/pe_input_feeder.sv
// Streams one row tile (pixel outer, channel inner) from the global buffer
// into a PE through a 2-entry FIFO with a rdy/ack handshake.
module pe_input_feeder #(
  parameter int DATAWD = 16,
  parameter int ADDRWD = 12,
  parameter int PCHWD  = 4,
  parameter int ROWWD  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDRWD-1:0] i_base_addr,
  input  logic [PCHWD-1:0]  i_pch,
  input  logic [ROWWD-1:0]  i_row_len,
  input  logic [ADDRWD-1:0] i_pch_stride,
  output logic              o_busy,
  output logic              o_done,
  pe_input_feeder_if.master bus
);

  localparam int CNTWD = PCHWD + ROWWD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [PCHWD-1:0]  pch_r;
  logic [PCHWD-1:0]  ch_cnt;
  logic [ROWWD-1:0]  row_len_r;
  logic [ROWWD-1:0]  pix_cnt;
  logic [ADDRWD-1:0] stride_r;
  logic [ADDRWD-1:0] pix_addr;
  logic [ADDRWD-1:0] rd_addr;
  logic [CNTWD-1:0]  xfer_left;
  logic [DATAWD-1:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_cnt;
  logic              rvalid;

  logic              pop;
  logic              flush;
  logic              issue;
  logic              last_ch;
  logic              last_rd;
  logic [2:0]        credit;

  // Read credit counts the word popped this cycle, so ack held high sustains
  // one read per cycle while a stalled PE caps outstanding words at two.
  always_comb begin
    pop     = (fifo_cnt != 2'd0) && bus.i_Input_ack;
    flush   = i_rst || i_abort;
    credit  = 3'(fifo_cnt) + 3'(rvalid) - 3'(pop);
    issue   = (state == RUN) && !flush && (credit < 3'd2);
    last_ch = (ch_cnt == pch_r - PCHWD'(1));
    last_rd = last_ch && (pix_cnt == row_len_r - ROWWD'(1));
  end

  assign bus.o_sram_ren   = issue;
  assign bus.o_sram_raddr = rd_addr;
  assign bus.o_Input_rdy  = (fifo_cnt != 2'd0);
  assign bus.o_Input_data = fifo_mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      pch_r     <= '0;
      row_len_r <= '0;
      stride_r  <= '0;
      ch_cnt    <= '0;
      pix_cnt   <= '0;
      pix_addr  <= '0;
      rd_addr   <= '0;
      xfer_left <= '0;
      rvalid    <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (i_abort) begin
      // Drop queued words and the read returning next cycle.
      state    <= IDLE;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      rvalid   <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      o_done   <= 1'b0;
      rvalid   <= issue;
      fifo_cnt <= fifo_cnt + 2'(rvalid) - 2'(pop);
      if (rvalid) begin
        fifo_mem[wr_ptr] <= bus.i_sram_rdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        xfer_left <= xfer_left - CNTWD'(1);
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            state     <= RUN;
            o_busy    <= 1'b1;
            pch_r     <= i_pch;
            row_len_r <= i_row_len;
            stride_r  <= i_pch_stride;
            ch_cnt    <= '0;
            pix_cnt   <= '0;
            pix_addr  <= i_base_addr;
            rd_addr   <= i_base_addr;
            xfer_left <= CNTWD'(i_pch) * CNTWD'(i_row_len);
          end
        end
        RUN: begin
          if (issue) begin
            if (last_ch) begin
              ch_cnt   <= '0;
              pix_cnt  <= pix_cnt + ROWWD'(1);
              pix_addr <= pix_addr + ADDRWD'(1);
              rd_addr  <= pix_addr + ADDRWD'(1);
            end else begin
              ch_cnt  <= ch_cnt + PCHWD'(1);
              rd_addr <= rd_addr + stride_r;
            end
            if (last_rd) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && (xfer_left == CNTWD'(1))) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_input_feeder.sv
// Directed bench for pe_input_feeder: a 1-cycle-latency buffer model returns
// {4'hD, address}, so every delivered word names the address it came from.
module tb_pe_input_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [11:0] base;
  logic [11:0] stride;
  logic [3:0]  pch;
  logic [7:0]  row_len;
  logic        busy;
  logic        done;

  int          vectors = 0;
  int          errors  = 0;
  logic [11:0] exp_addr [16];
  int          exp_n;

  always #5 clk = ~clk;

  pe_input_feeder_if #(.DATAWD(16), .ADDRWD(12)) bus ();

  pe_input_feeder #(.DATAWD(16), .ADDRWD(12), .PCHWD(4), .ROWWD(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_abort      (abort),
    .i_base_addr  (base),
    .i_pch        (pch),
    .i_row_len    (row_len),
    .i_pch_stride (stride),
    .o_busy       (busy),
    .o_done       (done),
    .bus          (bus)
  );

  always @(posedge clk) begin
    if (bus.o_sram_ren) bus.i_sram_rdata <= {4'hD, bus.o_sram_raddr};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg36();
    base = 12'h100; pch = 4'd3; row_len = 8'd4; stride = 12'h040; exp_n = 12;
    exp_addr[0] = 12'h100; exp_addr[1]  = 12'h140; exp_addr[2]  = 12'h180;
    exp_addr[3] = 12'h101; exp_addr[4]  = 12'h141; exp_addr[5]  = 12'h181;
    exp_addr[6] = 12'h102; exp_addr[7]  = 12'h142; exp_addr[8]  = 12'h182;
    exp_addr[9] = 12'h103; exp_addr[10] = 12'h143; exp_addr[11] = 12'h183;
  endtask

  // mode 0: ack high, 1: ack ~30% with a mid-run start, 2: ack low for 20 cycles
  task automatic run_seq(input int mode);
    int ridx = 0, xfers = 0, first_rdy = -1, first_x = -1, last_x = -1;
    bit prev_hold = 1'b0, fin = 1'b0, exp_done;
    logic [15:0] prev_data = 16'h0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      case (mode)
        1:       bus.i_Input_ack = ($urandom_range(0, 9) < 3);
        2:       bus.i_Input_ack = (cyc >= 20);
        default: bus.i_Input_ack = 1'b1;
      endcase
      if (mode == 1 && cyc == 5) begin
        start = 1'b1;
        base  = 12'h007;
      end else begin
        start = 1'b0;
      end
      #1;
      if (bus.o_Input_rdy && first_rdy < 0) first_rdy = cyc;
      if (prev_hold) begin
        check("hold_rdy", 32'(bus.o_Input_rdy), 32'd1);
        check("hold_data", 32'(bus.o_Input_data), 32'(prev_data));
      end
      if (bus.o_sram_ren) begin
        check("read_in_range", 32'(ridx < exp_n), 32'd1);
        if (ridx < exp_n) check("raddr", 32'(bus.o_sram_raddr), 32'(exp_addr[ridx]));
        ridx++;
      end
      exp_done = (xfers == exp_n) && (cyc == last_x + 1);
      check("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        check("busy_after_done", 32'(busy), 32'd0);
        fin = 1'b1;
      end
      if (mode == 2 && cyc == 19) check("reads_while_stalled", 32'(ridx), 32'd2);
      if (bus.o_Input_rdy && bus.i_Input_ack) begin
        check("xfer_in_range", 32'(xfers < exp_n), 32'd1);
        if (xfers < exp_n) check("data", 32'(bus.o_Input_data), {20'h0000D, exp_addr[xfers]});
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        xfers++;
      end
      prev_hold = bus.o_Input_rdy && !bus.i_Input_ack;
      prev_data = bus.o_Input_data;
      step();
    end
    check("finished", 32'(fin), 32'd1);
    check("xfer_count", 32'(xfers), 32'(exp_n));
    check("read_count", 32'(ridx), 32'(exp_n));
    if (mode == 0) check("first_rdy_latency", 32'(first_rdy), 32'd2);
    if (mode != 1) check("back_to_back", 32'(last_x - first_x), 32'(exp_n - 1));
  endtask

  initial begin
    int n;
    int hold;
    rst = 1'b1; start = 1'b0; abort = 1'b0; bus.i_Input_ack = 1'b0;
    base = 12'h0; stride = 12'h0; pch = 4'd1; row_len = 8'd1; exp_n = 1;
    step();
    step();
    rst = 1'b0;
    check("rst_rdy", 32'(bus.o_Input_rdy), 32'd0);
    check("rst_data", 32'(bus.o_Input_data), 32'd0);
    check("rst_ren", 32'(bus.o_sram_ren), 32'd0);
    check("rst_raddr", 32'(bus.o_sram_raddr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    cfg36(); run_seq(0);
    cfg36(); run_seq(1);
    cfg36(); run_seq(2);

    base = 12'h2A5; pch = 4'd1; row_len = 8'd1; stride = 12'h010; exp_n = 1;
    exp_addr[0] = 12'h2A5;
    run_seq(0);

    base = 12'hFFE; pch = 4'd2; row_len = 8'd2; stride = 12'h001; exp_n = 4;
    exp_addr[0] = 12'hFFE; exp_addr[1] = 12'hFFF; exp_addr[2] = 12'hFFF; exp_addr[3] = 12'h000;
    run_seq(0);

    // abort after 5 transfers while the PE stalls
    cfg36();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    hold = 0;
    for (int cyc = 0; cyc < 60 && hold < 3; cyc++) begin
      bus.i_Input_ack = (n < 5);
      #1;
      if (bus.o_Input_rdy && bus.i_Input_ack) n++;
      if (n == 5 && !bus.i_Input_ack) hold++;
      step();
    end
    check("abort_pre_count", 32'(n), 32'd5);
    check("abort_pre_rdy", 32'(bus.o_Input_rdy), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_rdy", 32'(bus.o_Input_rdy), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ren", 32'(bus.o_sram_ren), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort_quiet_rdy", 32'(bus.o_Input_rdy), 32'd0);
      check("abort_quiet_done", 32'(done), 32'd0);
    end
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start_with_abort_busy", 32'(busy), 32'd0);
    cfg36(); run_seq(0);

    // reset mid-transfer discards the read returning afterwards
    cfg36();
    bus.i_Input_ack = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_rdy", 32'(bus.o_Input_rdy), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_data", 32'(bus.o_Input_data), 32'd0);
    check("mrst_ren", 32'(bus.o_sram_ren), 32'd0);
    step();
    check("mrst_discard_rdy", 32'(bus.o_Input_rdy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
